// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the 16-bit data memory; 32-bit accesses run as two beats.
// Optional round-robin arbitration when DMEM_ARB_RR_EN is defined (default: fixed i > p).
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                p_req,
  input  logic                p_we,
  input  logic                p_dbl,
  input  logic [ADDR_W-1:0]   p_addr,
  input  logic [2*DATA_W-1:0] p_wdata,
  output logic [2*DATA_W-1:0] p_rdata,
  output logic                p_done,
  output logic                p_stall,
  input  logic                i_req,
  input  logic                i_we,
  input  logic                i_dbl,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [2*DATA_W-1:0] i_wdata,
  output logic [2*DATA_W-1:0] i_rdata,
  output logic                i_done,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {IDLE, P_B0, P_B1, I_B0, I_B1} state_t;

  state_t              state;
  logic                cur_we;
  logic                cur_dbl;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_wlo;
  logic [DATA_W-1:0]   w0;
`ifdef DMEM_ARB_RR_EN
  logic                last_p;
`endif

  logic                i_elig, p_elig, grant_i, grant_p;
  logic                g_we, g_dbl;
  logic [ADDR_W-1:0]   g_addr;
  logic [2*DATA_W-1:0] g_wdata;
  logic                owner_p, last_beat;
  logic [2*DATA_W-1:0] read_word;

  // A requester in its done cycle is masked so the other one can be granted without a bubble.
  always_comb begin
    i_elig = i_req & ~i_done;
    p_elig = p_req & ~p_done;
`ifdef DMEM_ARB_RR_EN
    grant_i = i_elig & (~p_elig | last_p);
`else
    grant_i = i_elig;
`endif
    grant_p   = p_elig & ~grant_i;
    g_we      = grant_i ? i_we    : p_we;
    g_dbl     = grant_i ? i_dbl   : p_dbl;
    g_addr    = grant_i ? i_addr  : p_addr;
    g_wdata   = grant_i ? i_wdata : p_wdata;
    owner_p   = (state == P_B0) || (state == P_B1);
    last_beat = (state == P_B1) || (state == I_B1) || !cur_dbl;
    read_word = cur_dbl ? {w0, mem_rdata} : {{DATA_W{1'b0}}, mem_rdata};
  end

  assign p_stall   = p_req & ~p_done;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur_we    <= 1'b0;
      cur_dbl   <= 1'b0;
      cur_addr  <= '0;
      cur_wlo   <= '0;
      w0        <= '0;
      p_rdata   <= '0;
      i_rdata   <= '0;
      p_done    <= 1'b0;
      i_done    <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef DMEM_ARB_RR_EN
      last_p    <= 1'b1;
`endif
    end else begin
      p_done <= 1'b0;
      i_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i || grant_p) begin
            state     <= grant_i ? I_B0 : P_B0;
            cur_we    <= g_we;
            cur_dbl   <= g_dbl;
            cur_addr  <= g_addr;
            cur_wlo   <= g_wdata[DATA_W-1:0];
            mem_addr  <= g_addr;
            mem_read  <= ~g_we;
            mem_write <= g_we;
            // High word goes first on a two-beat write.
            mem_wdata <= !g_we ? '0 :
                         (g_dbl ? g_wdata[2*DATA_W-1:DATA_W] : g_wdata[DATA_W-1:0]);
`ifdef DMEM_ARB_RR_EN
            last_p    <= grant_p;
`endif
          end
        end
        P_B0, P_B1, I_B0, I_B1: begin
          if (!cur_we && (state == P_B0 || state == I_B0)) w0 <= mem_rdata;
          if (last_beat) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (owner_p) begin
              p_done <= 1'b1;
              if (!cur_we) p_rdata <= read_word;
            end else begin
              i_done <= 1'b1;
              if (!cur_we) i_rdata <= read_word;
            end
          end else begin
            state     <= owner_p ? P_B1 : I_B1;
            mem_addr  <= cur_addr + ADDR_W'(1);
            mem_wdata <= cur_we ? cur_wlo : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed timing cases plus randomized traffic from both requesters,
// data checked against a word-level memory model through per-requester expected queues.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p_req = 0, p_we = 0, p_dbl = 0;
  logic [15:0] p_addr = 0;
  logic [31:0] p_wdata = 0;
  logic [31:0] p_rdata;
  logic        p_done, p_stall;
  logic        i_req = 0, i_we = 0, i_dbl = 0;
  logic [15:0] i_addr = 0;
  logic [31:0] i_wdata = 0;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        mem_read, mem_write, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  dbg_state;

  logic [15:0] mem [65536];
  logic [15:0] ref_mem [65536];
  logic [31:0] exp_q_p[$];
  logic [31:0] exp_q_i[$];
  logic [31:0] last_p_rd, last_i_rd;
  logic        rr_last_p;
  int          checks = 0;
  int          errors = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_dbl(p_dbl), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_done(p_done), .p_stall(p_stall),
    .i_req(i_req), .i_we(i_we), .i_dbl(i_dbl), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_done(i_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / memory instance model
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: word memory with 32-bit values split high word first.
  function automatic void push(int who, logic we, logic dbl, logic [15:0] a, logic [31:0] wd);
    logic [15:0] a1;
    logic [31:0] rd;
    a1 = a + 16'd1;
    rd = dbl ? {ref_mem[a], ref_mem[a1]} : {16'h0000, ref_mem[a]};
    if (we) begin
      if (dbl) begin
        ref_mem[a]  = wd[31:16];
        ref_mem[a1] = wd[15:0];
      end else begin
        ref_mem[a] = wd[15:0];
      end
      rd = (who == 0) ? last_p_rd : last_i_rd;
    end
    if (who == 0) begin
      last_p_rd = rd;
      exp_q_p.push_back(rd);
    end else begin
      last_i_rd = rd;
      exp_q_i.push_back(rd);
    end
  endfunction

  function automatic void drive(int who, logic req, logic we, logic dbl, logic [15:0] a,
                                logic [31:0] wd);
    if (who == 0) begin
      p_req = req; p_we = we; p_dbl = dbl; p_addr = a; p_wdata = wd;
    end else begin
      i_req = req; i_we = we; i_dbl = dbl; i_addr = a; i_wdata = wd;
    end
  endfunction

  task automatic access(input int who, input logic we, input logic dbl, input logic [15:0] a,
                        input logic [31:0] wd);
    logic got;
    got = 1'b0;
    push(who, we, dbl, a, wd);
    drive(who, 1'b1, we, dbl, a, wd);
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      got = (who == 0) ? p_done : i_done;
    end
    if (who == 0) check("p_done_seen", 32'(got), 32'd1);
    else          check("i_done_seen", 32'(got), 32'd1);
    drive(who, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  // Monitor: invariants every cycle, and data against the expected queues on each done pulse.
  always @(negedge clk) begin
    #1;
    check("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
    if (!busy) check("idle_mem_off", 32'({mem_read, mem_write}), 32'd0);
    check("p_stall", 32'(p_stall), 32'(p_req & ~p_done));
    if (p_done) begin
      if (exp_q_p.size() == 0) check("p_unexpected_done", 32'd1, 32'd0);
      else check("p_rdata", p_rdata, exp_q_p.pop_front());
    end
    if (i_done) begin
      if (exp_q_i.size() == 0) check("i_unexpected_done", 32'd1, 32'd0);
      else check("i_rdata", i_rdata, exp_q_i.pop_front());
    end
  end

  initial begin
    int bad;
    logic win_i;
    logic [31:0] wd;
    for (int a = 0; a < 65536; a++) begin
      mem[16'(a)]     = 16'($urandom);
      ref_mem[16'(a)] = mem[16'(a)];
    end
    last_p_rd = 32'h0;
    last_i_rd = 32'h0;
    rr_last_p = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_ctrl", 32'({mem_read, mem_write, p_done, i_done, busy}), 32'd0);
    check("reset_p_rdata", p_rdata, 32'd0);
    check("reset_i_rdata", i_rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // single read on p
    mem[16'h0010] = 16'hBEEF;
    ref_mem[16'h0010] = 16'hBEEF;
    push(0, 1'b0, 1'b0, 16'h0010, 32'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0010, 32'h0);
    #1 check("t1_stall_n", 32'(p_stall), 32'd1);
    @(negedge clk);
    check("t1_mem_read", 32'({mem_read, mem_write}), 32'b10);
    check("t1_mem_addr", 32'(mem_addr), 32'h0010);
    check("t1_stall_n1", 32'(p_stall), 32'd1);
    @(negedge clk);
    check("t1_done", 32'(p_done), 32'd1);
    check("t1_rdata", p_rdata, 32'h0000BEEF);
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);

    // double write on i wrapping past 0xFFFF
    push(1, 1'b1, 1'b1, 16'hFFFF, 32'h12345678);
    drive(1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 32'h12345678);
    @(negedge clk);
    check("t2_beat0", {mem_addr, mem_wdata}, 32'hFFFF1234);
    check("t2_write", 32'({mem_read, mem_write}), 32'b01);
    @(negedge clk);
    check("t2_beat1", {mem_addr, mem_wdata}, 32'h00005678);
    @(negedge clk);
    check("t2_done", 32'(i_done), 32'd1);
    check("t2_mem_hi", 32'(mem[16'hFFFF]), 32'h1234);
    check("t2_mem_lo", 32'(mem[16'h0000]), 32'h5678);
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);

    // contention: i first, p granted in the i_done cycle
    push(1, 1'b0, 1'b0, 16'hFF80, 32'h0);
    push(0, 1'b0, 1'b0, 16'h1020, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 16'hFF80, 32'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 16'h1020, 32'h0);
    @(negedge clk);
    check("t3_i_addr", 32'(mem_addr), 32'hFF80);
    @(negedge clk);
    check("t3_i_done", 32'(i_done), 32'd1);
    check("t3_p_stall", 32'(p_stall), 32'd1);
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    check("t3_p_addr", 32'({mem_read, mem_addr}), {15'd0, 1'b1, 16'h1020});
    @(negedge clk);
    check("t3_p_done", 32'(p_done), 32'd1);
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);

    // no preemption of a p burst
    push(0, 1'b0, 1'b1, 16'h1030, 32'h0);
    drive(0, 1'b1, 1'b0, 1'b1, 16'h1030, 32'h0);
    @(negedge clk);
    push(1, 1'b0, 1'b0, 16'hFF90, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 16'hFF90, 32'h0);
    check("t4_beat0", 32'(mem_addr), 32'h1030);
    @(negedge clk);
    check("t4_beat1", 32'(mem_addr), 32'h1031);
    @(negedge clk);
    check("t4_p_done", 32'(p_done), 32'd1);
    check("t4_idle", 32'({busy, mem_read}), 32'd0);
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    check("t4_i_access", 32'({mem_read, mem_addr}), {15'd0, 1'b1, 16'hFF90});
    @(negedge clk);
    check("t4_i_done", 32'(i_done), 32'd1);
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);

    // reset during the first beat of a double write
    wd = $urandom;
    drive(1, 1'b1, 1'b1, 1'b1, 16'h0040, wd);
    @(negedge clk);
    check("t5_pre_write", 32'(mem_write), 32'd1);
    rst = 1'b0;
    #1;
    check("t5_async_off", 32'({mem_read, mem_write, busy, i_done}), 32'd0);
    check("t5_async_addr", 32'(mem_addr), 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    last_p_rd = 32'h0;
    last_i_rd = 32'h0;
    rr_last_p = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t5_stays_idle", 32'({busy, i_done, p_done}), 32'd0);
    end

    // simultaneous requests three times; the loser withdraws after the winner completes
    for (int k = 0; k < 3; k++) begin
`ifdef DMEM_ARB_RR_EN
      win_i = rr_last_p;
`else
      win_i = 1'b1;
`endif
      push(win_i ? 1 : 0, 1'b0, 1'b0, win_i ? 16'(16'hFFA0 + k) : 16'(16'h1050 + k), 32'h0);
      drive(1, 1'b1, 1'b0, 1'b0, 16'(16'hFFA0 + k), 32'h0);
      drive(0, 1'b1, 1'b0, 1'b0, 16'(16'h1050 + k), 32'h0);
      @(negedge clk);
      check("t6_grant", 32'(mem_addr), win_i ? 32'(16'hFFA0 + k) : 32'(16'h1050 + k));
      @(negedge clk);
      check("t6_win_done", 32'(win_i ? i_done : p_done), 32'd1);
      drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
      drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
      rr_last_p = ~win_i;
      @(negedge clk);
      check("t6_gap_idle", 32'(busy), 32'd0);
    end

    // randomized concurrent traffic, each requester in its own address region
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          access(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'($urandom_range(16'h1000, 16'h10FF)), $urandom);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        for (int n = 0; n < 60; n++) begin
          access(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'($urandom_range(16'hFF00, 16'hFFFF)), $urandom);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    join

    repeat (5) @(negedge clk);
    check("p_queue_empty", 32'(exp_q_p.size()), 32'd0);
    check("i_queue_empty", 32'(exp_q_i.size()), 32'd0);
    bad = 0;
    for (int a = 0; a < 65536; a++) if (mem[16'(a)] !== ref_mem[16'(a)]) bad++;
    check("mem_image", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
